// File: rtl/div_iter_unit_if.sv
// Handshake between the EX-stage ALU (master) and the iterative divider (slave).
interface div_iter_unit_if #(
    parameter int DATA_W = 32
);
    logic                  div_start;
    logic                  div_sign;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  div_ready;
    logic [2*DATA_W-1:0]   div_result;
    logic                  div_busy;

    modport master (
        output div_start, div_sign, a, b,
        input  div_ready, div_result, div_busy
    );

    modport slave (
        input  div_start, div_sign, a, b,
        output div_ready, div_result, div_busy
    );
endinterface

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, result {rem, quo}.
// Divides magnitudes and fixes signs on the final step (C truncation).
// Optional feature macro: DIV_EARLY_OUT_EN -- finish in one cycle when
// |a| < |b|, skipping the iteration.
module div_iter_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    div_iter_unit_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_quo;   // holds the dividend; quotient bits shift in from the LSB
    logic [DATA_W-1:0]     r_div;
    logic                  r_qneg;
    logic                  r_rneg;
    logic                  r_ready;
    logic                  r_busy;
    logic [2*DATA_W-1:0]   r_result;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_abs;
    logic [DATA_W-1:0]     w_b_abs;
    logic [DATA_W:0]       w_rem_sh;
    logic [DATA_W:0]       w_trial;
    logic [DATA_W-1:0]     w_rem_nxt;
    logic [DATA_W-1:0]     w_quo_nxt;
    logic [DATA_W-1:0]     w_rem_fix;
    logic [DATA_W-1:0]     w_quo_fix;
    logic                  w_last;

    // Operand magnitudes, one restoring step, and the final sign fix-up.
    always_comb begin
        w_a_neg   = bus.div_sign & bus.a[DATA_W-1];
        w_b_neg   = bus.div_sign & bus.b[DATA_W-1];
        w_a_abs   = w_a_neg ? ({DATA_W{1'b0}} - bus.a) : bus.a;
        w_b_abs   = w_b_neg ? ({DATA_W{1'b0}} - bus.b) : bus.b;
        // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
        w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
        w_trial   = w_rem_sh - {1'b0, r_div};
        w_rem_nxt = w_trial[DATA_W] ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
        w_quo_nxt = {r_quo[DATA_W-2:0], ~w_trial[DATA_W]};
        w_quo_fix = r_qneg ? ({DATA_W{1'b0}} - w_quo_nxt) : w_quo_nxt;
        w_rem_fix = r_rneg ? ({DATA_W{1'b0}} - w_rem_nxt) : w_rem_nxt;
        w_last    = (r_cnt == CNT_W'(DATA_W - 1));
    end

    // Control FSM and datapath registers; ready/busy/result are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (bus.div_start) begin
                        r_rem  <= '0;
                        r_quo  <= w_a_abs;
                        r_div  <= w_b_abs;
                        r_qneg <= bus.div_sign & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                        r_rneg <= w_a_neg;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.b == '0) begin
                            // Divide by zero: all-ones quotient, raw dividend as remainder.
                            r_result <= {bus.a, {DATA_W{1'b1}}};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end
`ifdef DIV_EARLY_OUT_EN
                        else if (w_a_abs < w_b_abs) begin
                            r_result <= {bus.a, {DATA_W{1'b0}}};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end
`endif
                        else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!bus.div_start) begin
                        // ALU withdrew the request: abort silently, result untouched.
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Start may still be high here; it is ignored until IDLE.
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_ready  = r_ready;
    assign bus.div_busy   = r_busy;
    assign bus.div_result = r_result;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: latency, signs, div-by-zero, overflow,
// abort, back-to-back, mid-op reset and the optional early-out path.
module tb_div_iter_unit;
    localparam int DW = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    div_iter_unit_if #(.DATA_W(DW)) bus();

    div_iter_unit #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] av, input logic [31:0] bv);
        bus.div_start = 1'b1;
        bus.div_sign  = s;
        bus.a         = av;
        bus.b         = bv;
    endtask

    // Count edges until div_ready is seen; -1 if it never shows within limit.
    task automatic wait_ready(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.div_ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // One full operation from IDLE, then drop start and check the pulse ends.
    task automatic op(input string tag, input logic s, input logic [31:0] av,
                      input logic [31:0] bv, input int exp_lat, input logic [63:0] exp_res);
        int n;
        drive(s, av, bv);
        wait_ready(60, n);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, bus.div_result, exp_res);
        bus.div_start = 1'b0;
        tick();
        check({tag, "_pulse"}, {63'd0, bus.div_ready}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        bus.div_start = 1'b0;
        bus.div_sign  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {63'd0, bus.div_ready}, 64'd0);
        check("rst_busy",   {63'd0, bus.div_busy},  64'd0);
        check("rst_result", bus.div_result, 64'd0);
        rst = 1'b1;
        tick();

        // Unsigned 7/2 with operand changes mid-operation (must be ignored)
        drive(1'b0, 32'd7, 32'd2);
        tick();
        check("u7_2_busy", {63'd0, bus.div_busy}, 64'd1);
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'd0;
        bus.div_sign = 1'b1;
        wait_ready(60, n);
        check("u7_2_lat", 64'(n + 1), 64'd33);
        check("u7_2_res", bus.div_result, 64'h00000001_00000003);
        check("u7_2_busy_done", {63'd0, bus.div_busy}, 64'd1);
        bus.div_start = 1'b0;
        tick();
        check("u7_2_pulse", {63'd0, bus.div_ready}, 64'd0);
        check("u7_2_idle_busy", {63'd0, bus.div_busy}, 64'd0);
        check("u7_2_hold", bus.div_result, 64'h00000001_00000003);

        // Signed cases
        op("sn7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,          33, 64'hFFFFFFFF_FFFFFFFD);
        op("s7_n2",   1'b1, 32'd7,         32'hFFFF_FFFE,  33, 64'h00000001_FFFFFFFD);
        op("sn7_n2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  33, 64'hFFFFFFFF_00000003);

        // Divide by zero, signed and unsigned
        op("div0_s",  1'b1, 32'h1234_5678, 32'd0,          1,  64'h12345678_FFFFFFFF);
        op("div0_u",  1'b0, 32'hFFFF_FFF0, 32'd0,          1,  64'hFFFFFFF0_FFFFFFFF);

        // Signed overflow wraps
        op("ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  33, 64'h00000000_80000000);

        // Abort at T+10, restart 100/7 at T+12 -> ready at T+45
        drive(1'b0, 32'd7, 32'd2);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.div_ready === 1'b1) seen = 1;
        end
        bus.div_start = 1'b0;
        tick();
        if (bus.div_ready === 1'b1) seen = 1;
        check("abort_noready", 64'(seen), 64'd0);
        check("abort_busy",    {63'd0, bus.div_busy}, 64'd0);
        check("abort_hold",    bus.div_result, 64'h00000000_80000000);
        tick();
        drive(1'b0, 32'd100, 32'd7);
        wait_ready(60, n);
        check("abort_restart_lat", 64'(n + 12), 64'd45);
        check("abort_restart_res", bus.div_result, 64'h00000002_0000000E);
        bus.div_start = 1'b0;
        tick();

        // Back-to-back with start held through ready
        drive(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_ready(60, n);
        check("b2b1_lat", 64'(n), 64'd33);
        check("b2b1_res", bus.div_result, 64'h0000000F_0FFFFFFF);
        drive(1'b0, 32'd9, 32'd3);
        wait_ready(60, n);
        check("b2b2_gap", 64'(n), 64'd34);
        check("b2b2_res", bus.div_result, 64'h00000000_00000003);
        bus.div_start = 1'b0;
        tick();

        // Early-out candidates (|a| < |b|), same result either way
        op("eo_u3_5",  1'b0, 32'd3,         32'd5, EO_LAT, 64'h00000003_00000000);
        op("eo_sn3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, EO_LAT, 64'hFFFFFFFD_00000000);

        // Reset mid-operation
        drive(1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        check("mrst_busy",   {63'd0, bus.div_busy},  64'd0);
        check("mrst_ready",  {63'd0, bus.div_ready}, 64'd0);
        check("mrst_result", bus.div_result, 64'd0);
        bus.div_start = 1'b0;
        tick();
        rst = 1'b1;
        wait_ready(40, n);
        check("mrst_noready", 64'(n), 64'(-1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider; the responder side of the div_start/div_sign/div_ready/div_result handshake driven by the execute-stage ALU.
- Computes signed or unsigned 32-bit quotient and remainder, packed for direct write to HI/LO.
- Sits beside the ALU in the EX stage. The ALU holds div_start high, stalling the pipeline, until div_ready pulses.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- div_start  input  1  request; held high by the ALU until the div_ready cycle; dropping it early means abort.
- div_sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start in IDLE.
- a  input  DATA_W  dividend (rs); sampled with start in IDLE.
- b  input  DATA_W  divisor (rt); sampled with start in IDLE.
- div_ready  output  1  one-cycle pulse; div_result is valid in that cycle.
- div_result  output  2*DATA_W  {remainder, quotient}; [63:32]=HI=remainder, [31:0]=LO=quotient.
- div_busy  output  1  high in BUSY and DONE; debug/perf visibility.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, div_ready=0, div_result=0, div_busy=0, counter=0, internal operand registers=0.
- States:
  - IDLE: on div_start=1, latch |a| and |b|, the quotient sign (a[31]^b[31], signed only) and the remainder sign (a[31], signed only).
    - If b==0, go to DONE.
    - Otherwise go to BUSY with counter=0.
  - BUSY: one restoring step per cycle.
    - Shift {rem,quo} left 1.
    - trial = rem - divisor, computed DATA_W+1 bits wide.
    - If trial is non-negative, rem=trial and quo[0]=1; else quo[0]=0.
    - counter++. After the DATA_W-th step, go to DONE.
  - DONE: div_ready=1 and div_result driven from registers, then unconditionally go to IDLE.
- Latency: start sampled in IDLE at cycle T → BUSY in cycles T+1..T+32 → ready in cycle T+33.
  - Divide by zero: ready at T+1.
- Throughput: a new start is accepted in IDLE at T+34 (the cycle after DONE). A start still high during DONE is ignored.
- Abort: div_start=0 in any BUSY cycle → IDLE next edge, no ready pulse, div_result unchanged.
  - A start reasserted later begins a fresh operation using newly sampled operands.
- Sign fix-up, applied in the BUSY→DONE transition: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set. This matches C truncation semantics.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This is natural two's-complement wrap; no flag.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = a (raw input), for both signed and unsigned. No exception.
- Operand stability: a, b and div_sign are ignored outside IDLE; changing them mid-operation has no effect.
- div_result holds its last value between operations.
- Reset asserted mid-operation → IDLE immediately; no ready pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if |a| < |b| (unsigned compare of the magnitudes) and b != 0, go directly to DONE with quotient=0, remainder=a (raw). Ready at T+1.
  - Check order: b==0 first, then early-out.
- Undefined: no magnitude compare. Such operands take the full 33-cycle path and yield the identical result.

Test Plan:
- Unsigned 7/2: a=7, b=2, sign=0, start held → ready only in T+33; div_result=0x00000001_00000003.
- Signed -7/2: a=0xFFFFFFF9, b=2, sign=1 → div_result=0xFFFFFFFF_FFFFFFFD.
- Divide by zero and signed overflow:
  - a=0x12345678, b=0, sign=1 → ready at T+1; div_result=0x12345678_FFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF, sign=1 → 0x00000000_80000000 at T+33.
- Abort: start 7/2, drop start at T+10 → no ready; start 100/7 at T+12 → ready at T+45 with 0x00000002_0000000E.
- Back-to-back: DIVU 0xFFFFFFFF/0x10 (held through ready) → 0x0000000F_0FFFFFFF. Then start held high again the cycle after ready with 9/3 → second ready exactly 34 cycles after the first; result 0x00000000_00000003.
- Early-out: 3/5 unsigned → with DIV_EARLY_OUT_EN, ready at T+1; without it, ready at T+33. Both give 0x00000003_00000000.
